// File: rtl/y86_alu_if.sv
// Y86 ALU bus: operation request and registered result.
// Master drives operands, slave returns result and flags.
interface y86_alu_if;
  logic        en;
  logic [1:0]  control;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] ans;
  logic        overflow;
  logic        zf;
  logic        sf;

  modport master (
    output en,
    output control,
    output a,
    output b,
    input  ans,
    input  overflow,
    input  zf,
    input  sf
  );

  modport slave (
    input  en,
    input  control,
    input  a,
    input  b,
    output ans,
    output overflow,
    output zf,
    output sf
  );
endinterface

// File: rtl/y86_alu.sv
// Y86 64-bit ALU: add/sub/and/xor with one-cycle
// registered result and condition flags.
module y86_alu (
  input  logic       clk,
  input  logic       reset,
  y86_alu_if.slave   bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef struct packed {
    logic [63:0] ans;
    logic        overflow;
    logic        zf;
    logic        sf;
  } res_t;

  op_e         op;
  logic        is_sub;
  logic        is_arith;
  logic [63:0] b_eff;
  logic [63:0] sum;
  logic        sum_ovf;
  logic [63:0] raw;
  res_t        nxt;
  res_t        cur;

  assign op = op_e'(bus.control);

  // decode operation class
  always_comb begin
    is_sub   = 1'b0;
    is_arith = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): is_arith = 1'b1;
      (op == OP_SUB): begin
        is_arith = 1'b1;
        is_sub   = 1'b1;
      end
      (op == OP_AND),
      (op == OP_XOR): is_arith = 1'b0;
    endcase
  end

  // shared adder; sub is a + ~b + 1, carry-out dropped
  always_comb begin
    b_eff = is_sub ? ~bus.b : bus.b;
    sum   = bus.a + b_eff + {63'd0, is_sub};
  end

  // signed overflow: like-signed addends, differing sum sign
  always_comb begin
    sum_ovf = (bus.a[63] == b_eff[63]) &&
              (sum[63] != bus.a[63]);
  end

  // result select
  always_comb begin
    raw = sum;
    unique case (op)
      OP_ADD,
      OP_SUB: raw = sum;
      OP_AND: raw = bus.a & bus.b;
      OP_XOR: raw = bus.a ^ bus.b;
    endcase
  end

  // flags derived from the same value that will be stored
  always_comb begin
    nxt.ans      = raw;
    nxt.overflow = is_arith & sum_ovf;
    nxt.zf       = (raw == 64'd0);
    nxt.sf       = raw[63];
  end

  // result register; reset wins over enable
  always_ff @(posedge clk) begin
    if (reset) begin
      cur.ans      <= 64'd0;
      cur.overflow <= 1'b0;
      cur.zf       <= 1'b1;
      cur.sf       <= 1'b0;
    end else if (bus.en) begin
      cur <= nxt;
    end
  end

  assign bus.ans      = cur.ans;
  assign bus.overflow = cur.overflow;
  assign bus.zf       = cur.zf;
  assign bus.sf       = cur.sf;

endmodule

// File: tb/tb_y86_alu.sv
// Directed and randomized checks for y86_alu.
// Expected values come from hand constants and a wide model.
module tb_y86_alu;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  y86_alu_if bus ();

  y86_alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] e_ans,
    input logic        e_ovf,
    input logic        e_zf,
    input logic        e_sf
  );
    n_assert++;
    assert (bus.ans === e_ans) else begin
      n_fail++;
      $error("FAIL %s ans: got %h want %h", tag, bus.ans, e_ans);
    end
    n_assert++;
    assert (bus.overflow === e_ovf) else begin
      n_fail++;
      $error("FAIL %s ovf: got %b want %b", tag, bus.overflow, e_ovf);
    end
    n_assert++;
    assert (bus.zf === e_zf) else begin
      n_fail++;
      $error("FAIL %s zf: got %b want %b", tag, bus.zf, e_zf);
    end
    n_assert++;
    assert (bus.sf === e_sf) else begin
      n_fail++;
      $error("FAIL %s sf: got %b want %b", tag, bus.sf, e_sf);
    end
  endtask

  task automatic drive(
    input logic        e,
    input logic [1:0]  c,
    input logic [63:0] x,
    input logic [63:0] y
  );
    bus.en      = e;
    bus.control = c;
    bus.a       = x;
    bus.b       = y;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [66:0] ref_op(
    input logic [1:0]  c,
    input logic [63:0] x,
    input logic [63:0] y
  );
    logic [64:0] w;
    logic [63:0] r;
    logic        v;
    w = '0;
    v = 1'b0;
    case (c)
      2'b00: begin
        w = {x[63], x} + {y[63], y};
        r = w[63:0];
        v = w[64] ^ w[63];
      end
      2'b01: begin
        w = {x[63], x} - {y[63], y};
        r = w[63:0];
        v = w[64] ^ w[63];
      end
      2'b10: r = x & y;
      default: r = x ^ y;
    endcase
    return {r, v, (r == 64'd0), r[63]};
  endfunction

  logic [66:0] m;
  logic [66:0] m_next;
  logic [1:0]  rc;
  logic [63:0] ra;
  logic [63:0] rb;
  logic        re;
  logic [63:0] pick [4];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b1, 2'b00, 64'd5, 64'd3);

    tick();
    chk("reset", 64'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("reset2", 64'd0, 1'b0, 1'b1, 1'b0);

    reset = 1'b0;
    tick();
    chk("add5_3", 64'd8, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 2'b01, 64'd3, 64'd5);
    tick();
    chk("sub3_5", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);

    drive(1'b1, 2'b01, 64'h8000_0000_0000_0000, 64'd1);
    tick();
    chk("sub_min", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    tick();
    chk("add_max", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);

    drive(1'b1, 2'b10, 64'hF0F0, 64'h0FF0);
    tick();
    chk("and", 64'h00F0, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 2'b11, 64'h1234, 64'h1234);
    tick();
    chk("xor_eq", 64'd0, 1'b0, 1'b1, 1'b0);

    drive(1'b1, 2'b01, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001);
    tick();
    chk("sub_xx", 64'd0, 1'b0, 1'b1, 1'b0);

    drive(1'b1, 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    tick();
    chk("add_negov", 64'd0, 1'b1, 1'b1, 1'b0);

    drive(1'b1, 2'b11, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_FFFF_FFFF);
    tick();
    chk("xor_neg", 64'hFFFF_0000_0000_FFFF, 1'b0, 1'b0, 1'b1);

    drive(1'b1, 2'b00, 64'd5, 64'd3);
    tick();
    chk("hold_pre", 64'd8, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b11, 64'd1, 64'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold", 64'd8, 1'b0, 1'b0, 1'b0);
    end
    bus.en = 1'b1;
    tick();
    chk("hold_rel", 64'd3, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 2'b01, 64'd3, 64'd5);
    tick();
    drive(1'b0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    #3;
    chk("midcyc", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);

    drive(1'b1, 2'b00, 64'd9, 64'd9);
    reset = 1'b1;
    tick();
    chk("rst_prio", 64'd0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;

    m = {64'd0, 1'b0, 1'b1, 1'b0};
    pick[0] = 64'h7FFF_FFFF_FFFF_FFFF;
    pick[1] = 64'h8000_0000_0000_0000;
    pick[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    pick[3] = 64'd0;
    for (int i = 0; i < 400; i++) begin
      rc = 2'($urandom_range(0, 3));
      re = ($urandom_range(0, 3) != 0);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0)
        ra = pick[$urandom_range(0, 3)];
      if ($urandom_range(0, 4) == 0)
        rb = pick[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0)
        rb = ra;
      drive(re, rc, ra, rb);
      m_next = ref_op(rc, ra, rb);
      if (re)
        m = m_next;
      tick();
      chk("rand", m[66:3], m[2], m[1], m[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/y86_alu.md
Y86_ALU -- requirements
Module: y86_alu

Interface
REQ-001 The block SHALL expose the following ports:
  - clk  input  1  single clock; all state updates on rising edge.
  - reset  input  1  synchronous, active-high reset.
  - en  input  1  capture enable; result registers update only when high.
  - control  input  2  operation select: 00 add, 01 sub, 10 and, 11 xor.
  - a  input  64  signed operand A.
  - b  input  64  signed operand B.
  - ans  output  64  registered signed result.
  - overflow  output  1  registered two's-complement overflow of the captured operation.
  - zf  output  1  registered zero flag: ans == 0.
  - sf  output  1  registered sign flag: ans[63].
REQ-002 The block SHALL use one clock, with synchronous active-high reset named reset; there SHALL be no asynchronous paths to state.
REQ-003 The block SHALL have no parameters; width is fixed at 64 bits.

Function
REQ-004 The raw result SHALL be combinational from a, b and control:
  - 00: a + b
  - 01: a - b, computed as a + ~b + 1
  - 10: a & b
  - 11: a ^ b
REQ-005 Arithmetic SHALL be modulo 2^64; the carry-out SHALL be discarded and not exposed.
REQ-006 Add overflow SHALL be set when a[63] == b[63] and result[63] != a[63].
REQ-007 Sub overflow SHALL be set when a[63] != b[63] and result[63] != a[63].
REQ-008 Overflow for and/xor SHALL be 0.
REQ-009 On a rising clk with reset=0 and en=1, the block SHALL capture:
  - ans <= raw result
  - overflow <= raw overflow
  - zf <= (raw result == 0)
  - sf <= raw result[63]
REQ-010 Latency SHALL be exactly one cycle: operands presented before edge N appear on the outputs after edge N.
REQ-011 With en=0 (and reset=0), all outputs SHALL hold their previous values.
REQ-012 zf, sf and overflow SHALL always describe the value currently held in ans; they SHALL never be updated independently of it.
REQ-013 Operand changes between edges SHALL NOT affect the outputs until the next enabled edge.
REQ-014 Boundary cases:
  - 0x7FFF_FFFF_FFFF_FFFF + 1 -> 0x8000_0000_0000_0000, overflow=1, sf=1.
  - 0x8000_0000_0000_0000 - 1 -> 0x7FFF_FFFF_FFFF_FFFF, overflow=1, sf=0.
  - x - x -> 0, zf=1, overflow=0.
REQ-015 The full 64-bit result SHALL be computed in a single cycle; there SHALL be no multi-cycle or iterative operation.

Reset
REQ-016 When reset=1 at a rising clk, the block SHALL set ans=0, overflow=0, zf=1 and sf=0, regardless of en, control and the operands.
REQ-017 Reset SHALL take priority over en: an operation presented in the same cycle as reset is discarded.
REQ-018 After reset deasserts, the first enabled edge SHALL produce a normal result with no extra latency.
REQ-019 Before the first clock edge, outputs are undefined; the bench SHALL apply reset for at least one cycle.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - reset=1 with a=5, b=3, control=00, en=1 -> after the edge: ans=0, zf=1, sf=0, overflow=0.
  - control=00, a=5, b=3, en=1 -> next cycle: ans=8, zf=0, sf=0, overflow=0.
  - control=01, a=3, b=5 -> ans=-2 (0xFFFF_FFFF_FFFF_FFFE), sf=1, overflow=0; then a=0x8000_0000_0000_0000, b=1 -> ans=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
  - control=00, a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> ans=0x8000_0000_0000_0000, overflow=1, sf=1.
  - control=10, a=0xF0F0, b=0x0FF0 -> ans=0x00F0; then control=11, a=b=0x1234 -> ans=0, zf=1, overflow=0.
  - Compute ans=8, then drive en=0 with control=11, a=1, b=2 for 3 cycles -> ans stays 8 and flags are unchanged; en=1 -> ans=3.
REQ-021 The bench SHALL also run randomized operands and control values and check every output against a reference model each cycle.
